// File: rtl/alu_muldiv_if.sv
// alu_muldiv request/result bundle.
// Request and result each use a valid/ready pair; kill aborts.
interface alu_muldiv_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] A_alu;
  logic [XLEN-1:0] B_alu;
  logic [OP_W-1:0] control_alu;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result_alu;
  logic            zero_alu;
  logic            busy;

  modport master (
    output in_valid,
    output A_alu,
    output B_alu,
    output control_alu,
    output kill,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result_alu,
    input  zero_alu,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  A_alu,
    input  B_alu,
    input  control_alu,
    input  kill,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result_alu,
    output zero_alu,
    output busy
  );
endinterface

// File: rtl/alu_muldiv.sv
// Integer ALU with iterative multiply and restoring divide.
// Single-cycle ops finish in one cycle; MUL*/DIV* take XLEN.
module alu_muldiv #(
  parameter int XLEN = 32,
  parameter int OP_W = 5
) (
  input logic         clk,
  input logic         rst_n,
  alu_muldiv_if.slave bus
);
  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  SMIN =
    {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [OP_W-1:0] OP_ADD    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB    = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR     = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR    = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLL    = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL    = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA    = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SLT    = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTU   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(16);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(17);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(18);
  localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(19);
  localparam logic [OP_W-1:0] OP_DIV    = OP_W'(20);
  localparam logic [OP_W-1:0] OP_DIVU   = OP_W'(21);
  localparam logic [OP_W-1:0] OP_REM    = OP_W'(22);
  localparam logic [OP_W-1:0] OP_REMU   = OP_W'(23);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [OP_W-1:0]   r_op;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN-1:0]   r_result;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg_a;
  logic              r_neg_b;

  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [OP_W-1:0] w_op;
  logic [SH_W-1:0] w_shamt;
  logic            w_fire;
  logic            w_is_mul;
  logic            w_is_div;
  logic            w_na;
  logic            w_nb;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_dz;
  logic            w_ovf;
  logic            w_iter;
  logic [XLEN-1:0] w_quick;

  assign w_a     = bus.A_alu;
  assign w_b     = bus.B_alu;
  assign w_op    = bus.control_alu;
  assign w_shamt = w_b[SH_W-1:0];
  assign w_fire  = bus.in_valid & ~bus.kill &
                   (r_state == S_IDLE);

  assign w_is_mul = w_op inside
    {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  assign w_is_div = w_op inside
    {OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  // Only operands treated as signed contribute a sign.
  assign w_na = w_a[XLEN-1] & (w_op inside
    {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign w_nb = w_b[XLEN-1] & (w_op inside
    {OP_MUL, OP_MULH, OP_DIV, OP_REM});

  assign w_mag_a = w_na ? -w_a : w_a;
  assign w_mag_b = w_nb ? -w_b : w_b;
  assign w_dz    = (w_b == '0);
  assign w_ovf   = (w_op == OP_DIV || w_op == OP_REM) &&
                   (w_a == SMIN) && (w_b == '1);
  assign w_iter  = w_is_mul | (w_is_div & ~w_dz & ~w_ovf);

  always_comb begin
    w_quick = '0;
    case (w_op)
      OP_ADD:  w_quick = w_a + w_b;
      OP_SUB:  w_quick = w_a - w_b;
      OP_AND:  w_quick = w_a & w_b;
      OP_OR:   w_quick = w_a | w_b;
      OP_XOR:  w_quick = w_a ^ w_b;
      OP_SLL:  w_quick = w_a << w_shamt;
      OP_SRL:  w_quick = w_a >> w_shamt;
      OP_SRA:  w_quick = $signed(w_a) >>> w_shamt;
      OP_SLT:  w_quick = {{(XLEN-1){1'b0}},
                          $signed(w_a) < $signed(w_b)};
      OP_SLTU: w_quick = {{(XLEN-1){1'b0}}, w_a < w_b};
      // Divide bypasses; the overflow case returns A for DIV.
      OP_DIV:  w_quick = w_dz ? '1 : w_a;
      OP_DIVU: w_quick = '1;
      OP_REM:  w_quick = w_dz ? w_a : '0;
      OP_REMU: w_quick = w_a;
      default: w_quick = '0;
    endcase
  end

  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_nxt;
  logic [XLEN:0]     w_trial;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_div_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_div_res;

  // r_acc: {partial product, multiplier} or {remainder, quotient}.
  assign w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                 (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_nxt = {w_sum, r_acc[XLEN-1:1]};

  // Borrow out of the trial subtract means "does not fit".
  assign w_trial = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_diff  = w_trial - {1'b0, r_opnd};
  assign w_div_nxt = {
    w_diff[XLEN] ? w_trial[XLEN-1:0] : w_diff[XLEN-1:0],
    r_acc[XLEN-2:0],
    ~w_diff[XLEN]
  };

  assign w_prod = (r_neg_a ^ r_neg_b) ? -w_mul_nxt
                                      : w_mul_nxt;
  assign w_mul_res = (r_op == OP_MUL) ? w_prod[XLEN-1:0]
                                      : w_prod[2*XLEN-1:XLEN];

  assign w_quo = w_div_nxt[XLEN-1:0];
  assign w_rem = w_div_nxt[2*XLEN-1:XLEN];
  assign w_div_res =
    (r_op == OP_DIV || r_op == OP_DIVU)
      ? ((r_neg_a ^ r_neg_b) ? -w_quo : w_quo)
      : (r_neg_a ? -w_rem : w_rem);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    bus.in_ready   = 1'b0;
    bus.busy       = 1'b0;
    bus.out_valid  = 1'b0;
    bus.result_alu = r_result;
    bus.zero_alu   = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (w_fire) begin
          if (w_is_mul)    w_next = S_MUL;
          else if (w_iter) w_next = S_DIV;
          else             w_next = S_DONE;
        end
      end
      S_MUL, S_DIV: begin
        bus.busy = 1'b1;
        if (bus.kill)                w_next = S_IDLE;
        else if (r_cnt == CNT_LAST)  w_next = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        bus.zero_alu  = (r_result == '0);
        if (bus.kill || bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_op    <= w_op;
            r_neg_a <= w_na;
            r_neg_b <= w_nb;
            r_cnt   <= '0;
            if (w_is_mul) begin
              r_acc  <= {{XLEN{1'b0}}, w_mag_b};
              r_opnd <= w_mag_a;
            end else begin
              r_acc  <= {{XLEN{1'b0}}, w_mag_a};
              r_opnd <= w_mag_b;
            end
            if (!w_iter) r_result <= w_quick;
          end
        end
        S_MUL, S_DIV: begin
          if (bus.kill) begin
            r_cnt <= '0;
          end else begin
            r_acc <= (r_state == S_MUL) ? w_mul_nxt
                                        : w_div_nxt;
            if (r_cnt == CNT_LAST) begin
              r_cnt    <= '0;
              r_result <= (r_state == S_MUL) ? w_mul_res
                                             : w_div_res;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: arithmetic reference model checked
// every cycle, plus directed vectors with literal results.
module tb_alu_muldiv;
  localparam int XLEN = 32;
  localparam int OP_W = 5;

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1;
  localparam logic [4:0] AND = 5'd2, OR = 5'd3, XOR = 5'd4;
  localparam logic [4:0] SLL = 5'd5, SRL = 5'd6, SRA = 5'd7;
  localparam logic [4:0] SLT = 5'd8, SLTU = 5'd9;
  localparam logic [4:0] MUL = 5'd16, MULH = 5'd17;
  localparam logic [4:0] MULHSU = 5'd18, MULHU = 5'd19;
  localparam logic [4:0] DIV = 5'd20, DIVU = 5'd21;
  localparam logic [4:0] REM = 5'd22, REMU = 5'd23;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_muldiv_if #(.XLEN(XLEN), .OP_W(OP_W)) bus ();

  alu_muldiv #(.XLEN(XLEN), .OP_W(OP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  int          cyc    = 0;
  bit          m_pend = 1'b0;
  int          m_at   = 0;
  logic [31:0] m_res  = '0;
  logic [31:0] m_reg  = '0;
  bit          chk_en = 1'b0;

  function automatic logic [31:0] ref_res(
    logic [4:0] op, logic [31:0] a, logic [31:0] b);
    longint          sa, sb, ps;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      ADD:  return a + b;
      SUB:  return a - b;
      AND:  return a & b;
      OR:   return a | b;
      XOR:  return a ^ b;
      SLL:  return a << b[4:0];
      SRL:  return a >> b[4:0];
      SRA:  return $signed(a) >>> b[4:0];
      SLT:  return {31'd0, $signed(a) < $signed(b)};
      SLTU: return {31'd0, a < b};
      MUL: begin ps = sa * sb; return ps[31:0]; end
      MULH: begin ps = sa * sb; return ps[63:32]; end
      MULHSU: begin
        ps = sa * longint'(ua);
        return ps[63:32];
      end
      MULHU: begin pu = ua * ub; return pu[63:32]; end
      DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return a;
        ps = sa / sb;
        return ps[31:0];
      end
      REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 32'd0;
        ps = sa % sb;
        return ps[31:0];
      end
      DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REMU: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Extra cycles beyond the single-cycle case.
  function automatic int ref_extra(
    logic [4:0] op, logic [31:0] a, logic [31:0] b);
    if (op inside {MUL, MULH, MULHSU, MULHU}) return XLEN;
    if (op inside {DIVU, REMU}) return (b == 0) ? 0 : XLEN;
    if (op inside {DIV, REM}) begin
      if (b == 0) return 0;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      return XLEN;
    end
    return 0;
  endfunction

  task automatic check1(string nm, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b",
               nm, cyc, act, exp);
    end
  endtask

  task automatic check32(string nm, logic [31:0] act,
                         logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin : model
    bit vld;
    vld = m_pend && (cyc >= m_at);
    if (!rst_n) begin
      m_pend = 1'b0;
      m_reg  = '0;
      chk_en = 1'b1;
    end else if (!m_pend) begin
      if (bus.in_valid && !bus.kill) begin
        m_pend = 1'b1;
        m_res  = ref_res(bus.control_alu, bus.A_alu,
                         bus.B_alu);
        m_at   = cyc + 1 + ref_extra(bus.control_alu,
                                     bus.A_alu, bus.B_alu);
      end
    end else if (bus.kill || (vld && bus.out_ready)) begin
      m_pend = 1'b0;
    end
    cyc++;
  end

  always @(negedge clk) begin : compare
    bit ev;
    if (chk_en) begin
      ev = m_pend && (cyc >= m_at);
      if (ev) m_reg = m_res;
      check1("out_valid", bus.out_valid, ev);
      check1("in_ready", bus.in_ready, !m_pend);
      check1("busy", bus.busy, m_pend && (cyc < m_at));
      check1("zero_alu", bus.zero_alu, ev && (m_reg == 0));
      check32("result_alu", bus.result_alu, m_reg);
    end
  end

  task automatic issue(logic [4:0] op, logic [31:0] a,
                       logic [31:0] b);
    bus.control_alu = op;
    bus.A_alu       = a;
    bus.B_alu       = b;
    bus.in_valid    = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid    = 1'b0;
    bus.A_alu       = $urandom;
    bus.B_alu       = $urandom;
    bus.control_alu = 5'($urandom);
  endtask

  task automatic run(string nm, logic [4:0] op,
                     logic [31:0] a, logic [31:0] b,
                     logic [31:0] exp, int lat);
    int k;
    k = 0;
    issue(op, a, b);
    do begin
      @(negedge clk);
      k++;
    end while (!bus.out_valid && k < 60);
    check32({nm, " result"}, bus.result_alu, exp);
    check32({nm, " latency"}, 32'(k), 32'(lat));
    check1({nm, " zero"}, bus.zero_alu, exp == 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic quiet(string nm, int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check32(nm, 32'(seen), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid    = 1'b0;
    bus.kill        = 1'b0;
    bus.out_ready   = 1'b0;
    bus.A_alu       = '0;
    bus.B_alu       = '0;
    bus.control_alu = '0;
    rst_n           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check32("model MULH",
      ref_res(MULH, 32'h8000_0000, 32'h8000_0000),
      32'h4000_0000);
    check32("model MULHSU",
      ref_res(MULHSU, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    check32("model DIV",
      ref_res(DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check32("model REM",
      ref_res(REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    run("ADD wrap", ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run("SUB", SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1);
    run("AND", AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0,
        32'h00F0_00F0, 1);
    run("OR", OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0,
        32'hFFF0_FFF0, 1);
    run("XOR", XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0,
        32'hFF00_FF00, 1);
    run("SLL", SLL, 32'd1, 32'h0000_003F, 32'h8000_0000, 1);
    run("SRL", SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 1);
    run("SRA", SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1);
    run("SLT", SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run("SLTU", SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run("undef10", 5'd10, 32'd5, 32'd6, 32'd0, 1);
    run("undef31", 5'd31, 32'd5, 32'd6, 32'd0, 1);
    run("MULH", MULH, 32'h8000_0000, 32'h8000_0000,
        32'h4000_0000, 33);
    run("MULHU", MULHU, 32'h8000_0000, 32'h8000_0000,
        32'h4000_0000, 33);
    run("MUL", MUL, 32'h8000_0000, 32'h8000_0000,
        32'd0, 33);
    run("MUL neg", MUL, 32'd12345, 32'hFFFF_FFFD,
        32'hFFFF_6F55, 33);
    run("MULHSU", MULHSU, 32'hFFFF_FFFF, 32'd2,
        32'hFFFF_FFFF, 33);
    run("DIV", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run("REM", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run("DIVU", DIVU, 32'd100, 32'd7, 32'd14, 33);
    run("REMU", REMU, 32'd100, 32'd7, 32'd2, 33);
    run("DIVU big", DIVU, 32'h8000_0000, 32'hFFFF_FFFF,
        32'd0, 33);
    run("DIVU by0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("REMU by0", REMU, 32'd5, 32'd0, 32'd5, 1);
    run("DIV ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h8000_0000, 1);
    run("REM ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF,
        32'd0, 1);

    // Held result with a competing request pending.
    issue(ADD, 32'd2, 32'd3);
    bus.control_alu = SUB;
    bus.A_alu       = 32'd9;
    bus.B_alu       = 32'd1;
    bus.in_valid    = 1'b1;
    repeat (11) @(negedge clk);
    check32("stall result", bus.result_alu, 32'd5);
    check1("stall in_ready", bus.in_ready, 1'b0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check1("stall released", bus.in_ready, 1'b1);

    // Abort a divide at N+5.
    issue(DIVU, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    @(negedge clk);
    check1("kill idle", bus.in_ready, 1'b1);
    quiet("kill no out_valid", 40);
    run("SUB after kill", SUB, 32'd3, 32'd5,
        32'hFFFF_FFFE, 1);

    // kill beats in_valid while idle.
    bus.kill        = 1'b1;
    bus.in_valid    = 1'b1;
    bus.control_alu = ADD;
    bus.A_alu       = 32'd1;
    bus.B_alu       = 32'd1;
    @(posedge clk);
    #1;
    bus.kill     = 1'b0;
    bus.in_valid = 1'b0;
    quiet("idle kill no accept", 3);

    // Abort from DONE keeps the last result.
    issue(OR, 32'h0000_000F, 32'h0000_00F0);
    @(negedge clk);
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    @(negedge clk);
    check1("done kill valid", bus.out_valid, 1'b0);
    check32("done kill result", bus.result_alu, 32'h0000_00FF);

    // Reset at N+10 of a MULHU.
    issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check32("reset result", bus.result_alu, 32'd0);
    check1("reset in_ready", bus.in_ready, 1'b1);
    check1("reset busy", bus.busy, 1'b0);
    quiet("reset no stale valid", 40);
    run("ADD after reset", ADD, 32'd7, 32'd8, 32'd15, 1);
    run("MULHU after reset", MULHU, 32'hFFFF_FFFF,
        32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
